// File: rtl/excp_ctrl.sv
// Exception/interrupt/ERTN commit controller: accepts one event at commit, then flushes and redirects fetch.
// Latency: event accepted in cycle T, FLUSH (CSR strobe) at T+1, redirect offered from T+2.
// Backpressure: wb_ready is low outside IDLE; REDIR holds redir_valid/redir_pc/flush until redir_ready.
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   wb_valid/wb_ready            commit handshake; wb_ex/wb_ertn/wb_ecode/wb_esubcode/wb_pc/wb_vaddr describe the commit
//   has_int/int_ecode            pending interrupt from the CSR file
//   csr_eentry/csr_era           redirect targets from the CSR file
//   csr_ex_en/csr_ecode/...      exception-entry update to the CSR file (non-zero only in FLUSH)
//   flush                        pipeline flush, high in FLUSH and REDIR
//   redir_valid/redir_pc/redir_ready  fetch redirect handshake
//   ex_cnt                       saturating count of exceptions/interrupts taken
module excp_ctrl #(
   parameter logic [7:0] ERTN_CODE = 8'hFF,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic             wb_ex,
   input  logic             wb_ertn,
   input  logic [7:0]       wb_ecode,
   input  logic             wb_esubcode,
   input  logic [31:0]      wb_pc,
   input  logic [31:0]      wb_vaddr,
   input  logic             has_int,
   input  logic [7:0]       int_ecode,
   input  logic [31:0]      csr_eentry,
   input  logic [31:0]      csr_era,
   output logic             csr_ex_en,
   output logic [7:0]       csr_ecode,
   output logic             csr_esubcode,
   output logic [31:0]      csr_pc,
   output logic [31:0]      csr_vaddr,
   output logic             flush,
   output logic             redir_valid,
   output logic [31:0]      redir_pc,
   input  logic             redir_ready,
   output logic [CNT_W-1:0] ex_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      REDIR = 2'd2
   } state_t;

   state_t state;
   logic   ev_ertn;   // current event is ERTN: redirect to ERA instead of EENTRY
   logic   take;

   assign take = wb_valid & (has_int | wb_ex | wb_ertn);

   // All outputs are registered. The csr_* payload is loaded on acceptance so it is
   // visible exactly during FLUSH, and cleared on the way out of FLUSH.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         ev_ertn      <= 1'b0;
         wb_ready     <= 1'b1;
         csr_ex_en    <= 1'b0;
         csr_ecode    <= 8'd0;
         csr_esubcode <= 1'b0;
         csr_pc       <= 32'd0;
         csr_vaddr    <= 32'd0;
         flush        <= 1'b0;
         redir_valid  <= 1'b0;
         redir_pc     <= 32'd0;
         ex_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state    <= FLUSH;
                  wb_ready <= 1'b0;
                  flush    <= 1'b1;
                  csr_pc   <= wb_pc;
                  // Priority: interrupt, then exception, then ERTN.
                  if (has_int) begin
                     ev_ertn      <= 1'b0;
                     csr_ex_en    <= 1'b1;
                     csr_ecode    <= int_ecode;
                     csr_esubcode <= 1'b0;
                     csr_vaddr    <= 32'd0;
                  end else if (wb_ex) begin
                     ev_ertn      <= 1'b0;
                     csr_ex_en    <= 1'b1;
                     csr_ecode    <= wb_ecode;
                     csr_esubcode <= wb_esubcode;
                     csr_vaddr    <= wb_vaddr;
                  end else begin
                     ev_ertn      <= 1'b1;
                     csr_ex_en    <= 1'b0;
                     csr_ecode    <= ERTN_CODE;
                     csr_esubcode <= 1'b0;
                     csr_vaddr    <= 32'd0;
                  end
               end
            end

            FLUSH: begin
               state        <= REDIR;
               csr_ex_en    <= 1'b0;
               csr_ecode    <= 8'd0;
               csr_esubcode <= 1'b0;
               csr_pc       <= 32'd0;
               csr_vaddr    <= 32'd0;
               redir_valid  <= 1'b1;
               redir_pc     <= ev_ertn ? csr_era : csr_eentry;
               // Count the entry strobe that is high during this cycle; ERTN never strobes.
               if (csr_ex_en && (ex_cnt != '1)) begin
                  ex_cnt <= ex_cnt + CNT_W'(1);
               end
            end

            REDIR: begin
               if (redir_ready) begin
                  state       <= IDLE;
                  redir_valid <= 1'b0;
                  flush       <= 1'b0;
                  wb_ready    <= 1'b1;
               end
            end

            default: begin
               state       <= IDLE;
               csr_ex_en   <= 1'b0;
               redir_valid <= 1'b0;
               flush       <= 1'b0;
               wb_ready    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_excp_ctrl.sv
// Self-checking bench for excp_ctrl (CNT_W=4 so saturation is reachable).
// Inputs are driven and outputs sampled on the falling clock edge.
// A per-event reference computes expected CSR payload, target and count.
module tb_excp_ctrl;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic          wb_valid, wb_ready, wb_ex, wb_ertn, wb_esubcode;
   logic [7:0]    wb_ecode, int_ecode;
   logic [31:0]   wb_pc, wb_vaddr, csr_eentry, csr_era;
   logic          has_int;
   logic          csr_ex_en, csr_esubcode, flush, redir_valid, redir_ready;
   logic [7:0]    csr_ecode;
   logic [31:0]   csr_pc, csr_vaddr, redir_pc;
   logic [CW-1:0] ex_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   excp_ctrl #(.ERTN_CODE(8'hFF), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
      .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
      .has_int(has_int), .int_ecode(int_ecode), .csr_eentry(csr_eentry), .csr_era(csr_era),
      .csr_ex_en(csr_ex_en), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
      .csr_pc(csr_pc), .csr_vaddr(csr_vaddr), .flush(flush),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
      .ex_cnt(ex_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_wb();
      wb_valid = 1'b0; has_int = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0;
   endtask

   // Drives one event from an IDLE falling edge and follows it back to IDLE.
   // Returns at the falling edge where the controller is ready for the next event.
   task automatic run_event(input logic hi, input logic ex, input logic er,
                            input logic [7:0] iec, input logic [7:0] ec, input logic sub,
                            input logic [31:0] pc, input logic [31:0] va,
                            input logic [31:0] eentry, input logic [31:0] era,
                            input int stall);
      logic [7:0]  e_ec;
      logic        e_sub, e_en;
      logic [31:0] e_tgt;
      // Reference: interrupt beats exception beats ERTN.
      e_en  = hi | ex;
      e_ec  = hi ? iec : (ex ? ec : 8'hFF);
      e_sub = hi ? 1'b0 : (ex ? sub : 1'b0);
      e_tgt = e_en ? eentry : era;

      chk("idle_wb_ready", 32'(wb_ready), 32'd1);
      wb_valid = 1'b1; has_int = hi; wb_ex = ex; wb_ertn = er;
      int_ecode = iec; wb_ecode = ec; wb_esubcode = sub; wb_pc = pc; wb_vaddr = va;
      csr_eentry = eentry; csr_era = era;
      @(posedge clk); #1;
      clear_wb();
      wb_pc = $urandom; wb_vaddr = $urandom; wb_ecode = 8'($urandom); int_ecode = 8'($urandom);

      @(negedge clk);   // T+1: FLUSH
      chk("t1_flush", 32'(flush), 32'd1);
      chk("t1_wb_ready", 32'(wb_ready), 32'd0);
      chk("t1_csr_ex_en", 32'(csr_ex_en), 32'(e_en));
      chk("t1_csr_ecode", 32'(csr_ecode), 32'(e_ec));
      chk("t1_csr_esubcode", 32'(csr_esubcode), 32'(e_sub));
      if (e_en) begin
         chk("t1_csr_pc", csr_pc, pc);
         if (!hi) chk("t1_csr_vaddr", csr_vaddr, va);
         exp_cnt = (exp_cnt + 1 > 15) ? 15 : exp_cnt + 1;
      end

      @(negedge clk);   // T+2: REDIR
      chk("t2_redir_valid", 32'(redir_valid), 32'd1);
      chk("t2_redir_pc", redir_pc, e_tgt);
      chk("t2_flush", 32'(flush), 32'd1);
      chk("t2_csr_ex_en", 32'(csr_ex_en), 32'd0);
      chk("t2_csr_ecode", 32'(csr_ecode), 32'd0);
      chk("t2_csr_pc", csr_pc, 32'd0);
      chk("t2_ex_cnt", 32'(ex_cnt), 32'(exp_cnt));

      for (int i = 0; i < stall; i++) begin
         csr_eentry = $urandom; csr_era = $urandom;
         @(negedge clk);
         chk("stall_redir_valid", 32'(redir_valid), 32'd1);
         chk("stall_redir_pc", redir_pc, e_tgt);
         chk("stall_flush", 32'(flush), 32'd1);
         chk("stall_wb_ready", 32'(wb_ready), 32'd0);
      end
      redir_ready = 1'b1;
      @(posedge clk); #1;
      redir_ready = 1'b0;
      @(negedge clk);
      chk("done_wb_ready", 32'(wb_ready), 32'd1);
      chk("done_redir_valid", 32'(redir_valid), 32'd0);
      chk("done_flush", 32'(flush), 32'd0);
   endtask

   initial begin
      rstn = 1'b0; redir_ready = 1'b0;
      clear_wb();
      wb_ecode = 8'd0; wb_esubcode = 1'b0; wb_pc = 32'd0; wb_vaddr = 32'd0;
      int_ecode = 8'd0; csr_eentry = 32'd0; csr_era = 32'd0;

      // Reset state.
      @(posedge clk); @(negedge clk);
      chk("rst_wb_ready", 32'(wb_ready), 32'd1);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_redir_valid", 32'(redir_valid), 32'd0);
      chk("rst_redir_pc", redir_pc, 32'd0);
      chk("rst_csr_ex_en", 32'(csr_ex_en), 32'd0);
      chk("rst_ex_cnt", 32'(ex_cnt), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_wb_ready", 32'(wb_ready), 32'd1);
      chk("post_rst_flush", 32'(flush), 32'd0);

      // Exception entry.
      run_event(1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 32'h1C00_0100, 32'h0000_BEEF,
                32'h1C00_8000, 32'h0, 0);
      chk("exc_cnt_one", 32'(ex_cnt), 32'd1);
      // ERTN: not counted.
      run_event(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 32'h1C00_0200, 32'h0,
                32'h1C00_8000, 32'h1C00_0104, 0);
      chk("ertn_cnt_unchanged", 32'(ex_cnt), 32'd1);
      // All three at once: interrupt wins.
      run_event(1'b1, 1'b1, 1'b1, 8'h4B, 8'h09, 1'b1, 32'h1C00_0300, 32'h1234,
                32'h1C00_9000, 32'h1C00_0104, 0);

      // Interrupt without a commit, and a commit without any event, are both ignored.
      has_int = 1'b1; int_ecode = 8'h4B;
      @(negedge clk);
      chk("int_novalid_ready", 32'(wb_ready), 32'd1);
      chk("int_novalid_flush", 32'(flush), 32'd0);
      has_int = 1'b0; wb_valid = 1'b1; redir_ready = 1'b1;
      @(negedge clk);
      chk("valid_noevent_flush", 32'(flush), 32'd0);
      chk("valid_noevent_redir", 32'(redir_valid), 32'd0);
      clear_wb(); redir_ready = 1'b0;

      // Redirect backpressure for 5 cycles.
      run_event(1'b0, 1'b1, 1'b0, 8'h00, 8'h21, 1'b1, 32'h1C00_0400, 32'hDEAD_0000,
                32'h1C00_A000, 32'h0, 5);

      // Randomized events.
      for (int n = 0; n < 25; n++) begin
         logic hi, ex, er;
         hi = 1'($urandom); ex = 1'($urandom); er = 1'($urandom);
         if (!(hi | ex | er)) er = 1'b1;
         run_event(hi, ex, er, 8'($urandom), 8'($urandom), 1'($urandom), $urandom, $urandom,
                   $urandom, $urandom, int'($urandom_range(0, 3)));
      end

      // Reset while in REDIR.
      wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 8'h05; csr_eentry = 32'h1C00_B000;
      @(posedge clk); #1; clear_wb();
      @(negedge clk); @(negedge clk);
      chk("pre_rst_redir_valid", 32'(redir_valid), 32'd1);
      rstn = 1'b0; #1;
      chk("mid_rst_redir_valid", 32'(redir_valid), 32'd0);
      chk("mid_rst_flush", 32'(flush), 32'd0);
      chk("mid_rst_ex_cnt", 32'(ex_cnt), 32'd0);
      chk("mid_rst_redir_pc", redir_pc, 32'd0);
      chk("mid_rst_wb_ready", 32'(wb_ready), 32'd1);
      exp_cnt = 0;
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
      chk("after_rst_redir_valid", 32'(redir_valid), 32'd0);
      chk("after_rst_wb_ready", 32'(wb_ready), 32'd1);

      // Reset while in FLUSH: entry strobe is dropped.
      wb_valid = 1'b1; has_int = 1'b1; int_ecode = 8'h40;
      @(posedge clk); #1; clear_wb();
      chk("flush_pre_rst_ex_en", 32'(csr_ex_en), 32'd1);
      rstn = 1'b0; #1;
      chk("flush_rst_ex_en", 32'(csr_ex_en), 32'd0);
      chk("flush_rst_ecode", 32'(csr_ecode), 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("flush_rst_no_redir", 32'(redir_valid), 32'd0);
      chk("flush_rst_cnt", 32'(ex_cnt), 32'd0);

      // Saturation: 17 exceptions.
      for (int n = 0; n < 17; n++) begin
         run_event(1'b0, 1'b1, 1'b0, 8'h00, 8'($urandom), 1'b0, $urandom, $urandom,
                   $urandom, $urandom, 0);
      end
      chk("sat_ex_cnt", 32'(ex_cnt), 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
